// File: rtl/adc_serial_emulator.sv
`default_nettype none
// ============================================================================
// Module  : adc_serial_emulator
// Purpose : ADC responder model - convst/busy handshake plus two-lane MSB-first
//           serial readout of the held sample set on the controller's sclk.
// Rev     : 1.0  initial release
// ============================================================================
module adc_serial_emulator #(
    parameter int W_DATA      = 18,
    parameter int N_CHAN      = 8,
    parameter int CONV_CYCLES = 200,
    parameter int TX_LEN      = W_DATA * N_CHAN / 2
) (
    input  logic                     clk_in,
    input  logic                     n_rst_in,
    input  logic                     convst_in,
    input  logic                     n_cs_in,
    input  logic                     sclk_in,
    input  logic [W_DATA*N_CHAN-1:0] chan_data_in,
    input  logic                     pattern_sel_in,
    output logic                     busy_out,
    output logic                     data_a_out,
    output logic                     data_b_out,
    output logic [15:0]              conv_count_out,
    output logic                     frame_done_out
);

    localparam int HALF  = N_CHAN / 2;
    localparam int W_CNT = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int W_BIT = $clog2(TX_LEN + 1);
    localparam int W_SUM = (W_DATA > 16) ? W_DATA : 16;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [2:0]        convst_sync;
    logic [2:0]        n_cs_sync;
    logic [2:0]        sclk_sync;
    logic              convst_rise;
    logic              n_cs_fall;
    logic              n_cs_rise;
    logic              sclk_fall;

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [W_CNT-1:0]  cyc_cnt;
    logic              capture;
    logic [15:0]       conv_count;

    logic [TX_LEN-1:0] sample_a;
    logic [TX_LEN-1:0] sample_b;
    logic [TX_LEN-1:0] hold_a;
    logic [TX_LEN-1:0] hold_b;
    logic [TX_LEN-1:0] shift_a;
    logic [TX_LEN-1:0] shift_b;
    logic [W_BIT-1:0]  bit_cnt;
    logic              active;

    // Bits [1:0] are the synchronizer, bit [2] is the edge-detector history.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            convst_sync <= '0;
            n_cs_sync   <= '0;
            sclk_sync   <= '0;
        end else begin
            convst_sync <= {convst_sync[1:0], convst_in};
            n_cs_sync   <= {n_cs_sync[1:0], n_cs_in};
            sclk_sync   <= {sclk_sync[1:0], sclk_in};
        end
    end

    assign convst_rise = convst_sync[1] & ~convst_sync[2];
    assign n_cs_fall   = ~n_cs_sync[1] & n_cs_sync[2];
    assign n_cs_rise   = n_cs_sync[1] & ~n_cs_sync[2];
    assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (convst_rise) state_next = S_CONV;
            S_CONV:  if (cyc_cnt == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state == S_CONV);
    end

    assign capture        = (state == S_CONV) && (cyc_cnt == '0);
    assign conv_count_out = conv_count;

    // Ramp uses the count before this capture's increment.
    for (genvar k = 0; k < HALF; k++) begin : g_lane
        logic [W_SUM-1:0] ramp_a;
        logic [W_SUM-1:0] ramp_b;
        assign ramp_a = W_SUM'(conv_count) + W_SUM'(k);
        assign ramp_b = W_SUM'(conv_count) + W_SUM'(k + HALF);
        assign sample_a[TX_LEN-1-k*W_DATA -: W_DATA] = pattern_sel_in ? ramp_a[W_DATA-1:0]
                                                     : chan_data_in[k*W_DATA +: W_DATA];
        assign sample_b[TX_LEN-1-k*W_DATA -: W_DATA] = pattern_sel_in ? ramp_b[W_DATA-1:0]
                                                     : chan_data_in[(k+HALF)*W_DATA +: W_DATA];
    end

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            cyc_cnt    <= '0;
            hold_a     <= '0;
            hold_b     <= '0;
            conv_count <= '0;
        end else begin
            if ((state == S_IDLE) && convst_rise) begin
                cyc_cnt <= W_CNT'(CONV_CYCLES - 1);
            end else if ((state == S_CONV) && (cyc_cnt != '0)) begin
                cyc_cnt <= cyc_cnt - 1'b1;
            end
            if (capture) begin
                hold_a     <= sample_a;
                hold_b     <= sample_b;
                conv_count <= conv_count + 16'd1;
            end
        end
    end

    // A chip-select fall in the capture cycle loads the freshly captured set.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            shift_a        <= '0;
            shift_b        <= '0;
            bit_cnt        <= '0;
            active         <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            if (n_cs_fall) begin
                active  <= 1'b1;
                shift_a <= capture ? sample_a : hold_a;
                shift_b <= capture ? sample_b : hold_b;
                bit_cnt <= '0;
            end else if (n_cs_rise) begin
                active <= 1'b0;
            end else if (active && sclk_fall) begin
                shift_a <= {shift_a[TX_LEN-2:0], 1'b0};
                shift_b <= {shift_b[TX_LEN-2:0], 1'b0};
                if (bit_cnt == W_BIT'(TX_LEN - 1)) begin
                    frame_done_out <= 1'b1;
                end
                if (bit_cnt != W_BIT'(TX_LEN)) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign data_a_out = active & shift_a[TX_LEN-1];
    assign data_b_out = active & shift_b[TX_LEN-1];

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_emulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_serial_emulator
// Purpose : Directed + randomized self-checking bench for adc_serial_emulator.
// Rev     : 1.0  initial release
// ============================================================================
module tb_adc_serial_emulator;

    localparam int W  = 18;
    localparam int N  = 8;
    localparam int CC = 200;
    localparam int TX = W * N / 2;

    typedef logic [TX-1:0] word_t;

    logic           clk     = 1'b0;
    logic           n_rst   = 1'b0;
    logic           convst  = 1'b0;
    logic           n_cs    = 1'b0;
    logic           sclk    = 1'b0;
    logic           pat     = 1'b0;
    logic [W*N-1:0] chan    = '0;
    logic           busy;
    logic           da;
    logic           db;
    logic           fdone;
    logic [15:0]    cnt;

    int total  = 0;
    int bad    = 0;
    int fd_cnt = 0;

    // Reference model: the held channel values and the conversion count.
    logic [W-1:0] m_ch [N];
    int unsigned  m_count = 0;

    adc_serial_emulator #(
        .W_DATA      (W),
        .N_CHAN      (N),
        .CONV_CYCLES (CC)
    ) dut (
        .clk_in         (clk),
        .n_rst_in       (n_rst),
        .convst_in      (convst),
        .n_cs_in        (n_cs),
        .sclk_in        (sclk),
        .chan_data_in   (chan),
        .pattern_sel_in (pat),
        .busy_out       (busy),
        .data_a_out     (da),
        .data_b_out     (db),
        .conv_count_out (cnt),
        .frame_done_out (fdone)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fdone === 1'b1) fd_cnt++;
    end

    task automatic check(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic word_t lane_word(input int base);
        word_t w = '0;
        for (int k = 0; k < N / 2; k++) w = {w[TX-W-1:0], m_ch[base+k]};
        return w;
    endfunction

    task automatic model_capture();
        for (int k = 0; k < N; k++)
            m_ch[k] = pat ? W'(m_count + k) : chan[k*W +: W];
        m_count = (m_count + 1) % 65536;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_ch[k] = '0;
        m_count = 0;
    endtask

    task automatic randomize_chan();
        for (int k = 0; k < N; k++) chan[k*W +: W] = W'($urandom);
    endtask

    // One conversion; optionally re-pulses convst retrig cycles into busy.
    task automatic convert(input bit timed, input int retrig);
        int hi = 0;
        convst = 1'b1;
        tick(2);
        if (timed) check("busy_latency", word_t'(busy), word_t'(0));
        tick(1);
        check("busy_rise", word_t'(busy), word_t'(1));
        convst = 1'b0;
        while (busy === 1'b1 && hi < 4 * CC) begin
            if (hi == retrig)     convst = 1'b1;
            if (hi == retrig + 3) convst = 1'b0;
            hi++;
            tick(1);
        end
        if (timed) check("busy_len", word_t'(hi), word_t'(CC));
        model_capture();
        tick(5);
        check("busy_idle", word_t'(busy), word_t'(0));
        check("conv_count", word_t'(cnt), word_t'(m_count[15:0]));
    endtask

    // Receiver: sample on the rising sclk edge, drive 6 clk per sclk period.
    task automatic read_frame(input int nbits, output word_t a, output word_t b);
        a = '0;
        b = '0;
        n_cs = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            a = {a[TX-2:0], da};
            b = {b[TX-2:0], db};
            sclk = 1'b1;
            tick(3);
            sclk = 1'b0;
            tick(3);
        end
        tick(3);
    endtask

    task automatic check_words(input string tag, input word_t a, input word_t b,
                               input word_t ea, input word_t eb, input int fd);
        check({tag, "_lane_a"}, a, ea);
        check({tag, "_lane_b"}, b, eb);
        check({tag, "_frame_done"}, word_t'(fd), word_t'(1));
        n_cs = 1'b1;
        tick(5);
        check({tag, "_idle_data"}, word_t'({da, db}), word_t'(0));
    endtask

    task automatic frame_check(input string tag);
        word_t a, b;
        int f0 = fd_cnt;
        read_frame(TX, a, b);
        check_words(tag, a, b, lane_word(0), lane_word(N / 2), fd_cnt - f0);
    endtask

    initial begin
        word_t a, b, old_a, old_b;
        int f0;
        model_reset();

        tick(2);
        n_rst = 1'b1;
        tick(10);
        check("rst_busy",  word_t'(busy),  word_t'(0));
        check("rst_da",    word_t'(da),    word_t'(0));
        check("rst_db",    word_t'(db),    word_t'(0));
        check("rst_fdone", word_t'(fdone), word_t'(0));
        check("rst_count", word_t'(cnt),   word_t'(0));

        n_cs = 1'b1;
        tick(5);
        convert(1'b1, 50);

        for (int k = 0; k < 6; k++) chan[k*W +: W] = W'((k + 1) * 'h1111);
        pat = 1'b0;
        convert(1'b1, -10);
        frame_check("frame_fixed");

        f0 = fd_cnt;
        read_frame(20, a, b);
        n_cs = 1'b1;
        tick(5);
        check("abort_da_db", word_t'({da, db}), word_t'(0));
        check("abort_prefix_a", a, lane_word(0) >> (TX - 20));
        check("abort_prefix_b", b, lane_word(N / 2) >> (TX - 20));
        check("abort_no_done", word_t'(fd_cnt - f0), word_t'(0));
        frame_check("restart");

        for (int r = 0; r < 3; r++) begin
            randomize_chan();
            pat = 1'($urandom);
            convert(1'b0, -10);
            frame_check("random");
        end

        // Read during busy; the capture then lands mid-frame.
        old_a = lane_word(0);
        old_b = lane_word(N / 2);
        randomize_chan();
        pat = 1'b0;
        convst = 1'b1;
        tick(3);
        convst = 1'b0;
        tick(10);
        f0 = fd_cnt;
        read_frame(TX, a, b);
        check_words("overlap", a, b, old_a, old_b, fd_cnt - f0);
        model_capture();
        check("overlap_count", word_t'(cnt), word_t'(m_count[15:0]));
        frame_check("after_overlap");

        // Chip-select fall lands in the same cycle as the capture.
        randomize_chan();
        convst = 1'b1;
        tick(3);
        convst = 1'b0;
        tick(197);
        f0 = fd_cnt;
        read_frame(TX, a, b);
        model_capture();
        check_words("coincide", a, b, lane_word(0), lane_word(N / 2), fd_cnt - f0);

        convst = 1'b1;
        tick(3);
        convst = 1'b0;
        tick(50);
        n_rst = 1'b0;
        #1;
        check("midrst_busy",  word_t'(busy), word_t'(0));
        check("midrst_count", word_t'(cnt),  word_t'(0));
        model_reset();
        tick(2);
        n_rst = 1'b1;
        tick(5);
        frame_check("post_reset");

        pat = 1'b1;
        for (int r = 0; r < 3; r++) convert(1'b0, -10);
        frame_check("ramp");

        force dut.conv_count = 16'hFFFF;
        tick(1);
        release dut.conv_count;
        m_count = 16'hFFFF;
        tick(1);
        check("preload_count", word_t'(cnt), word_t'(16'hFFFF));
        convert(1'b0, -10);
        frame_check("wrap_ramp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_serial_emulator.md
Name: adc_serial_emulator

Overview:
- Synthesizable model of the 8-channel simultaneous-sampling ADC serial interface, acting as the responder end of the ADC link.
- Answers convst with a busy pulse, then shifts two lanes of channel data out MSB-first while n_cs is low, on the controller's sclk.
- Used for on-board loopback self-test of the ADC controller / OSF / PID path without a physical ADC.
- Data comes either from a parallel input bus or from an internal ramp pattern.

Parameters:
- W_DATA, 18: bits per channel sample.
- N_CHAN, 8: number of channels; must be even.
- CONV_CYCLES, 200: busy duration in clk_in cycles; must be ≥ 1.
- TX_LEN, W_DATA*N_CHAN/2: derived constant; bits per lane per frame.

Ports:
- clk_in, input, 1: system clock; must run ≥ 6x the sclk_in frequency.
- n_rst_in, input, 1: reset, asynchronous, active-low.
- convst_in, input, 1: conversion start; the rising edge triggers a conversion.
- n_cs_in, input, 1: active-low chip select from the controller.
- sclk_in, input, 1: serial clock from the controller.
- chan_data_in, input, W_DATA*N_CHAN: channel k is bits [k*W_DATA +: W_DATA].
- pattern_sel_in, input, 1: 0 = use chan_data_in; 1 = use ramp pattern.
- busy_out, output, 1: conversion in progress.
- data_a_out, output, 1: lane A serial data, channels 0..N_CHAN/2-1.
- data_b_out, output, 1: lane B serial data, channels N_CHAN/2..N_CHAN-1.
- conv_count_out, output, 16: number of completed conversions.
- frame_done_out, output, 1: one-cycle pulse after TX_LEN bits have been shifted out.

Behaviour:
- Reset values: busy_out=0, data_a_out=0, data_b_out=0, conv_count_out=0, frame_done_out=0, holding register=0, FSM in IDLE.
- Reset asserted mid-operation aborts immediately to these values.
- Input synchronization: convst_in, n_cs_in and sclk_in each pass through a 2-FF synchronizer, then a registered edge detector. Edge-to-action latency is 3 clk_in cycles.
- Conversion FSM:
  - IDLE: on a convst rising edge, go to CONV, set busy_out=1, load the cycle counter with CONV_CYCLES-1.
  - CONV: decrement the counter each cycle. At 0, go to IDLE: busy_out=0, capture the sample set into the holding register, increment conv_count_out (wraps 0xFFFF→0x0000).
  - Busy is high for exactly CONV_CYCLES cycles.
  - Convst rising edges during CONV are ignored; there is no queuing.
- Sample set: when pattern_sel_in=0, chan_data_in sampled in the capture cycle. When pattern_sel_in=1, channel k = (conv_count_out + k) mod 2^W_DATA, using the pre-increment count.
- Lane packing:
  - Lane A word = {ch0, ch1, ..., ch(N/2-1)}.
  - Lane B word = {ch(N/2), ..., ch(N-1)}.
  - Each is TX_LEN bits, MSB first.
- Shift engine:
  - n_cs falling edge: load both shift registers from the holding register. data_*_out immediately present the MSB. Bit counter = 0.
  - While n_cs is low, each sclk falling edge shifts left with zero fill and increments the bit counter. The controller samples on sclk rising edges.
  - When the bit counter reaches TX_LEN-1 and another sclk falling edge arrives, pulse frame_done_out for 1 cycle. Further edges shift zeros with no further pulse.
  - n_cs high: data_*_out forced to 0 and sclk edges are ignored.
  - n_cs rising mid-frame aborts the frame with no frame_done_out.
- Boundary cases:
  - A frame read during CONV outputs the previous conversion's data.
  - A capture coinciding with an active frame does not disturb the shift registers; only the holding register updates.
  - Simultaneous n_cs fall and capture in the same cycle: the shift register loads the newly captured data.

Test Plan:
- Reset: release n_rst_in and hold all inputs low for 10 cycles → all outputs 0, conv_count_out=0.
- Basic conversion: CONV_CYCLES=200, pulse convst_in → busy_out rises 3 cycles after the edge and stays high exactly 200 cycles; conv_count_out becomes 1. A second convst pulsed 50 cycles into busy → no extra busy, count stays 1.
- Data frame:
  - Setup: chan0..5 = 1111, 2222, 3333, 4444, 5555, 6666; ch6=ch7=0; pattern_sel_in=0. Convert, then drop n_cs_in and issue 72 sclk falling edges at 1/6 of clk_in.
  - Expected: the receiver, sampling on rising edges, reconstructs lane A = {1111, 2222, 3333, 4444} and lane B = {5555, 6666, 0, 0}.
  - frame_done_out pulses once after the 72nd edge.
- Ramp pattern: pattern_sel_in=1, run 3 conversions, then read → lane A channels = 2, 3, 4, 5 and lane B = 6, 7, 8, 9.
- Abort: raise n_cs_in after 20 bits → data outputs 0, no frame_done_out. The next n_cs fall restarts from the MSB of ch0.
- Wrap and overlap:
  - Preload conv_count_out to 0xFFFF through 65535 conversions, or force it in simulation; the next conversion gives 0x0000.
  - A read started during busy returns the previous sample set.
